// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_reader
// Function : Drains a counted burst from a registered-read FIFO into a
//            valid/ready stream through a 2-entry skid buffer.
// Revision : 1.0  initial release
// ============================================================================
module fifo_reader #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              start_i,
  input  logic [CWIDTH-1:0] count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              fifo_rd_o,
  input  logic              fifo_empty_i,
  input  logic [DWIDTH-1:0] fifo_data_i,
  output logic              m_valid_o,
  output logic [DWIDTH-1:0] m_data_o,
  input  logic              m_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [CWIDTH:0]   count_q;
  logic [CWIDTH:0]   issued_q;
  logic [CWIDTH:0]   delivered_q;
  logic [CWIDTH:0]   delivered_d;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
  logic              inflight_q;
  logic [DWIDTH-1:0] buf0_q;
  logic [DWIDTH-1:0] buf0_d;
  logic [DWIDTH-1:0] buf1_q;
  logic [DWIDTH-1:0] buf1_d;

  logic              w_pop;
  logic              w_cap;
  logic              w_room;
  logic              w_rd;

  assign w_pop = en_i & (occ_q != 2'd0) & m_ready_i;
  assign w_cap = en_i & inflight_q;

  // Room test occ + inflight - pop < 2, rearranged to stay unsigned.
  assign w_room = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, w_pop});

  assign w_rd = en_i & (state_q == S_RUN) & (issued_q < count_q) &
                ~fifo_empty_i & w_room;

  assign delivered_d = delivered_q + {{CWIDTH{1'b0}}, w_pop};

  assign fifo_rd_o = w_rd;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = buf0_q;

  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({w_cap, w_pop})
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_data_i;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_data_i;
        end
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = fifo_data_i;
        end else begin
          buf1_d = fifo_data_i;
        end
        occ_d = occ_q + 2'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else if (en_i) begin
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      inflight_q  <= w_rd;
      issued_q    <= issued_q + {{CWIDTH{1'b0}}, w_rd};
      delivered_q <= delivered_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            count_q     <= {1'b0, count_i};
            issued_q    <= '0;
            delivered_q <= '0;
            busy_q      <= 1'b1;
            if (count_i != '0) begin
              state_q <= S_RUN;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issued_q == count_q) begin
            // The final pop may coincide with the cycle all reads are out.
            if (delivered_d == count_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (delivered_d == count_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_reader
// Function : Self-checking bench for fifo_reader with a behavioural FIFO.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_reader;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, en, start, m_ready;
  logic [CW-1:0] count;
  logic          busy, done, fifo_rd, m_valid, fifo_empty;
  logic [DW-1:0] m_data, fifo_dout;

  logic          fifo_rst, fifo_wr;
  logic [DW-1:0] fifo_wdata;
  logic [DW-1:0] fmem [16];
  int            fwp, frp, fcnt;

  always #5 clk = ~clk;

  fifo_reader #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .en_i(en), .start_i(start), .count_i(count),
    .busy_o(busy), .done_o(done), .fifo_rd_o(fifo_rd),
    .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_dout),
    .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(m_ready)
  );

  // Registered-read FIFO: dataOut appears the cycle after an accepted read.
  assign fifo_empty = (fcnt == 0);
  always @(posedge clk) begin
    if (fifo_rst) begin
      fwp <= 0; frp <= 0; fcnt <= 0; fifo_dout <= '0;
    end else if (en) begin
      if (fifo_wr && fcnt < 16) begin
        fmem[fwp] <= fifo_wdata;
        fwp <= (fwp + 1) % 16;
      end
      if (fifo_rd && fcnt != 0) begin
        fifo_dout <= fmem[frp];
        frp <= (frp + 1) % 16;
      end
      fcnt <= fcnt + ((fifo_wr && fcnt < 16) ? 1 : 0) - ((fifo_rd && fcnt != 0) ? 1 : 0);
    end
  end

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] shadow[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, rd_strobes = 0, rd_acc = 0, pops = 0, last_pop_cyc = -1, done_cyc = -1;

  typedef struct {
    int          cnt;
    logic [3:0]  pat;
    int          preload;
    logic [DW-1:0] base;
    int          exp_done;
    int          exp_left;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic cycle_end();
    @(negedge clk);
    chk("rd_guard", fifo_rd & (fifo_empty | ~en), 0);
    if (en && fifo_rd && !fifo_empty) begin
      rd_strobes++;
      rd_acc++;
    end
    if (en && m_valid && m_ready) begin
      pops++;
      last_pop_cyc = cyc;
      chk("sb_has_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("m_data", m_data, exp_q.pop_front());
    end
    if (en) chk("reads_ahead_le2", (rd_acc - pops) <= 2, 1);
    if (en && done) begin
      chk("busy_at_done", busy, 1);
      if (done_cyc < 0) done_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1; fifo_rst = 1; en = 1; start = 0; count = '0; m_ready = 0; fifo_wr = 0;
    cycle_end();
    cycle_end();
    rst = 0; fifo_rst = 0;
    exp_q.delete(); shadow.delete();
    rd_acc = 0; pops = 0;
  endtask

  task automatic fill(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fifo_wr = 1;
      fifo_wdata = base + DW'(i);
      shadow.push_back(fifo_wdata);
      cycle_end();
    end
    fifo_wr = 0;
  endtask

  task automatic run_burst(input int cnt, input logic [3:0] pat, input int exp_done, input int exp_left);
    for (int i = 0; i < cnt; i++) exp_q.push_back(shadow.pop_front());
    rd_strobes = 0; rd_acc = 0; pops = 0; done_cyc = -1; cyc = 0;
    start = 1; count = CW'(cnt); m_ready = pat[0];
    chk("busy_c0", busy, 0);
    cycle_end();
    start = 0;
    while (done_cyc < 0 && cyc < 200) begin
      m_ready = pat[cyc % 4];
      cycle_end();
    end
    chk("done_seen", done_cyc >= 0, 1);
    if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    chk("idle_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("rd_strobes", rd_strobes, cnt);
    chk("all_popped", exp_q.size(), 0);
    chk("fifo_left", fcnt, exp_left);
    exp_q.delete();
  endtask

  initial begin
    int wr_i;
    tbl[0] = '{cnt: 8,  pat: 4'b1111, preload: 8,  base: 8'h01, exp_done: 11, exp_left: 0};
    tbl[1] = '{cnt: 5,  pat: 4'b1001, preload: 8,  base: 8'h01, exp_done: 12, exp_left: 3};
    tbl[2] = '{cnt: 1,  pat: 4'b1111, preload: 3,  base: 8'h40, exp_done: 4,  exp_left: 2};
    tbl[3] = '{cnt: 0,  pat: 4'b1111, preload: 2,  base: 8'h80, exp_done: 1,  exp_left: 2};
    tbl[4] = '{cnt: 15, pat: 4'b1111, preload: 15, base: 8'hA0, exp_done: 18, exp_left: 0};
    tbl[5] = '{cnt: 3,  pat: 4'b0001, preload: 4,  base: 8'hF0, exp_done: 13, exp_left: 1};

    rst = 1; fifo_rst = 1; en = 1; start = 0; count = '0; m_ready = 0; fifo_wr = 0; fifo_wdata = '0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);

    foreach (tbl[k]) begin
      do_reset();
      fill(tbl[k].preload, tbl[k].base);
      run_burst(tbl[k].cnt, tbl[k].pat, tbl[k].exp_done, tbl[k].exp_left);
    end

    // Burst starts on an empty FIFO that is trickle-fed every third cycle.
    do_reset();
    exp_q.push_back(8'h0E); exp_q.push_back(8'h0D); exp_q.push_back(8'h0C); exp_q.push_back(8'h0B);
    rd_strobes = 0; rd_acc = 0; pops = 0; done_cyc = -1; last_pop_cyc = -1; cyc = 0; wr_i = 0;
    start = 1; count = 4'd4; m_ready = 1;
    cycle_end();
    start = 0;
    while (done_cyc < 0 && cyc < 100) begin
      fifo_wr = (cyc % 3 == 1) && (wr_i < 4);
      if (fifo_wr) begin
        fifo_wdata = 8'h0E - DW'(wr_i);
        wr_i++;
      end
      cycle_end();
    end
    fifo_wr = 0;
    chk("trickle_done_seen", done_cyc >= 0, 1);
    chk("trickle_done_after_pop", done_cyc, last_pop_cyc + 1);
    chk("trickle_rd_strobes", rd_strobes, 4);
    chk("trickle_all_popped", exp_q.size(), 0);

    // Enable low for three cycles with a word presented, then a stray start.
    do_reset();
    fill(6, 8'h21);
    for (int i = 0; i < 6; i++) exp_q.push_back(shadow.pop_front());
    rd_strobes = 0; rd_acc = 0; pops = 0; done_cyc = -1; cyc = 0;
    start = 1; count = 4'd6; m_ready = 1;
    cycle_end();
    start = 0;
    for (int i = 0; i < 4; i++) cycle_end();
    for (int i = 0; i < 3; i++) begin
      en = 0;
      #2;
      chk("en0_m_valid", m_valid, 1);
      chk("en0_m_data", m_data, exp_q[0]);
      chk("en0_fifo_rd", fifo_rd, 0);
      chk("en0_busy", busy, 1);
      cycle_end();
    end
    en = 1; start = 1; count = 4'd2;
    cycle_end();
    start = 0;
    while (done_cyc < 0 && cyc < 100) cycle_end();
    chk("en0_done_seen", done_cyc >= 0, 1);
    chk("en0_rd_strobes", rd_strobes, 6);
    chk("en0_all_popped", exp_q.size(), 0);
    chk("en0_fifo_left", fcnt, 0);
    cycle_end();
    chk("en0_idle", busy, 0);

    // Reset while the skid buffer is full, then a clean short burst.
    do_reset();
    fill(4, 8'h50);
    for (int i = 0; i < 4; i++) exp_q.push_back(shadow.pop_front());
    rd_acc = 0; pops = 0; cyc = 0;
    start = 1; count = 4'd4; m_ready = 0;
    cycle_end();
    start = 0;
    for (int i = 0; i < 4; i++) cycle_end();
    chk("full_m_valid", m_valid, 1);
    chk("full_m_data", m_data, exp_q[0]);
    chk("full_fifo_rd", fifo_rd, 0);
    rst = 1; fifo_rst = 1;
    cycle_end();
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_fifo_rd", fifo_rd, 0);
    chk("midrst_m_data", m_data, 0);
    chk("midrst_done", done, 0);
    rst = 0; fifo_rst = 0;
    exp_q.delete(); shadow.delete();
    rd_acc = 0; pops = 0;
    fill(2, 8'h66);
    run_burst(2, 4'b1111, 5, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_reader.md
# fifo_reader

Read-side engine for the synchronous `fifo` block. On a `start` command it drains exactly `count` words from the FIFO read port, absorbing the FIFO's one-cycle registered read latency. It presents the words on a valid/ready stream with a 2-entry skid buffer, then pulses `done`. It sits between the FIFO and any downstream consumer, for example a serializer or a DMA write port.

## Interface
Parameters:
- `DWIDTH`, 8, data word width; must match the FIFO's `DWIDTH`.
- `CWIDTH`, 4, width of the burst length `count`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  global enable; the same signal drives the FIFO's `en`. When low, nothing advances.
- `start`  in  1  burst request; sampled only in IDLE.
- `count`  in  CWIDTH  number of words in the burst; sampled with `start`.
- `busy`  out  1  high whenever `state != IDLE`.
- `done`  out  1  one-cycle pulse when a burst completes.
- `fifo_rd`  out  1  FIFO read strobe.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DWIDTH  FIFO `dataOut`. Valid in the cycle after a cycle in which `fifo_rd=1`, `fifo_empty=0` and `en=1`.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DWIDTH  output word.
- `m_ready`  in  1  downstream accepts `m_data` when `m_valid & m_ready & en`.

## Operation
- States:
  - IDLE: `start=1` with `count!=0` -> RUN; `start=1` with `count=0` -> DONE; otherwise stay in IDLE.
  - RUN: stay until `issued==count`. Then go to DRAIN, or to DONE when the last word has also been popped in that same cycle.
  - DRAIN: go to DONE when the buffer is empty and no read is in flight.
  - DONE: one cycle, then IDLE.
- Counters:
  - `issued` counts accepted FIFO reads; `delivered` counts stream pops.
  - Both are CWIDTH+1 bits wide and are cleared on `start`.
  - The burst ends when `delivered==count`; no wrap is possible.
- Read issue: `fifo_rd = en & (state==RUN) & (issued<count) & !fifo_empty & (occ + inflight - pop < 2)`.
  - `occ` is the skid-buffer occupancy (0..2).
  - `inflight` is the registered `fifo_rd & !fifo_empty` from the previous enabled cycle.
  - `pop = m_valid & m_ready`.
- `fifo_rd` is combinational from registered state and `fifo_empty`; it never depends on `m_ready` through more than the `pop` term.
- Skid buffer:
  - 2-entry FIFO ordering.
  - `m_data` is always the head entry; `m_valid = (occ != 0)`.
  - A capture (`inflight`) and a pop may occur in the same cycle; `occ` is then unchanged.
- `start` while `busy=1` is ignored. `count` changes after start have no effect.
- `en=0`:
  - `fifo_rd=0`; no pop, capture, counter or state change.
  - `m_valid` and `m_data` hold their values.
  - `done` holds; a pulse lasts one enabled cycle.
- Reset values: `busy=0`, `done=0`, `fifo_rd=0`, `m_valid=0`, `m_data=0`; occ=0, inflight=0, counters=0, state=IDLE.
- `rst` mid-burst: the block returns to IDLE on the next edge. Buffered and in-flight words are discarded, so words already popped from the FIFO are lost. The caller must reset the FIFO alongside.

## Timing
- The timeline below assumes `en=1`, `m_ready=1` and a FIFO that is not empty.
  - Cycle 0: `start=1` sampled.
  - Cycle 1: RUN, `busy=1`, first `fifo_rd=1`.
  - Cycle 2: `fifo_data` valid; captured at the end of the cycle.
  - Cycle 3: `m_valid=1`, first word on `m_data`.
- Sustained throughput is 1 word/cycle when `m_ready` is held high and the FIFO stays non-empty.
- For a burst of N words, the last pop is at cycle N+2. DONE (`done=1`) is at cycle N+3, then IDLE with `busy=0` at cycle N+4.
- `count=0`: `done` is asserted in cycle 1 and no `fifo_rd` is issued.
- With `m_ready=0`:
  - Reads stop once `occ + inflight = 2`; at most 2 words are ever pulled ahead of the consumer.
  - No data is lost or duplicated.
- FIFO empty mid-burst: `fifo_rd` drops while `fifo_empty=1` and resumes the cycle `fifo_empty` falls. The state stays RUN.

## Test plan
- FIFO preloaded with 1..8; `start`, `count=8`, `m_ready=1`.
  - Required: `m_data` shows 1..8 on consecutive cycles 3..10.
  - `done` pulses at cycle 11; 8 `fifo_rd` strobes in total.
- FIFO holds 8 words; `count=5`; `m_ready` toggles 1,0,0,1 repeating.
  - Required: exactly 5 pops, values 1..5 in order, never more than 2 reads ahead.
  - FIFO left with 3 words (`empty=0`).
- Burst with `count=4` into an empty FIFO; write 0xE, 0xD, 0xC, 0xB at 1 word every 3 cycles.
  - Required: `fifo_rd` only while `!fifo_empty`.
  - Outputs 0xE..0xB; `done` follows the last pop by 1 cycle.
- `count=0`.
  - Required: `done` in cycle 1, `busy` high only in cycle 1, no `fifo_rd`, `m_valid` stays 0.
- `en=0` for 3 cycles mid-burst with `m_valid=1`.
  - Required: `m_data` held, no `fifo_rd`, counters frozen.
  - Sequence resumes intact; `start` pulsed while busy has no effect.
- `rst` asserted with `occ=2`.
  - Required: next cycle `m_valid=0`, `busy=0`, `fifo_rd=0`.
  - A new `start`, `count=2` works normally.
